display_scan_controller: RTL and testbench

Time-multiplexed scan controller for the board's common-anode seven-segment display bank. It shares a single hex-to-seven-segment decoder across `NUM_DIGITS` digits. Each digit slot drives the 4-bit digit code to the decoder (`hex_out`) together with one active-low anode and the decimal-point line, with an anti-ghosting blank interval at each digit change. It sits between the counter/datapath, which supplies packed nibbles through a load strobe, and the decoder/pin outputs. Frame updates are double-buffered so the display never shows a torn value.

---
 rtl/display_scan_controller.sv | 168 ++++++++++++++++
 tb/tb_display_scan_controller.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/display_scan_controller.sv
// Time-multiplexed seven-segment scan controller with double-buffered
// frame data, anti-ghosting blank interval and leading-zero suppression.
module display_scan_controller #(
  parameter int NUM_DIGITS   = 8,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic                    lz_suppress,
  input  logic                    load,
  output logic [3:0]              hex_out,
  output logic [NUM_DIGITS-1:0]   anode,
  output logic                    dp_out,
  output logic                    frame_done
);

  localparam int SLOT_W = $clog2(REFRESH_DIV);
  localparam int IDX_W  = $clog2(NUM_DIGITS);

  localparam logic [SLOT_W-1:0] SLOT_LAST  = SLOT_W'(REFRESH_DIV - 1);
  localparam logic [SLOT_W-1:0] BLANK_LAST = SLOT_W'(BLANK_CYCLES - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

  typedef enum logic {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } state_e;

  state_e                  state_q, state_d;
  logic [SLOT_W-1:0]       slot_cnt_q, slot_cnt_d;
  logic [IDX_W-1:0]        digit_idx_q, digit_idx_d;
  logic [4*NUM_DIGITS-1:0] pend_dig_q, pend_dig_d;
  logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d;
  logic [NUM_DIGITS-1:0]   pend_en_q, pend_en_d;
  logic                    pend_valid_q, pend_valid_d;
  logic [4*NUM_DIGITS-1:0] act_dig_q, act_dig_d;
  logic [NUM_DIGITS-1:0]   act_dp_q, act_dp_d;
  logic [NUM_DIGITS-1:0]   act_en_q, act_en_d;
  logic                    lz_q, lz_d;
  logic                    frame_done_q, frame_done_d;

  logic slot_end;
  logic xfer;

  always_comb begin
    state_d      = state_q;
    slot_cnt_d   = slot_cnt_q + SLOT_W'(1);
    digit_idx_d  = digit_idx_q;
    pend_dig_d   = pend_dig_q;
    pend_dp_d    = pend_dp_q;
    pend_en_d    = pend_en_q;
    pend_valid_d = pend_valid_q;
    act_dig_d    = act_dig_q;
    act_dp_d     = act_dp_q;
    act_en_d     = act_en_q;
    lz_d         = lz_suppress;

    slot_end = (slot_cnt_q == SLOT_LAST);
    xfer     = slot_end && (digit_idx_q == IDX_LAST);
    frame_done_d = xfer;

    unique case (state_q)
      BLANK: begin
        if (slot_cnt_q == BLANK_LAST) state_d = DRIVE;
      end
      DRIVE: begin
        if (slot_end) begin
          state_d     = BLANK;
          slot_cnt_d  = '0;
          digit_idx_d = (digit_idx_q == IDX_LAST) ? '0
                        : digit_idx_q + IDX_W'(1);
        end
      end
      default: state_d = BLANK;
    endcase

    if (load) begin
      pend_dig_d   = digits_in;
      pend_dp_d    = dp_in;
      pend_en_d    = digit_en;
      pend_valid_d = 1'b1;
    end

    // A load on the boundary edge bypasses the pending buffer.
    unique case (1'b1)
      xfer && load: begin
        act_dig_d    = digits_in;
        act_dp_d     = dp_in;
        act_en_d     = digit_en;
        pend_valid_d = 1'b0;
      end
      xfer && !load && pend_valid_q: begin
        act_dig_d    = pend_dig_q;
        act_dp_d     = pend_dp_q;
        act_en_d     = pend_en_q;
        pend_valid_d = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= BLANK;
      slot_cnt_q   <= '0;
      digit_idx_q  <= '0;
      pend_dig_q   <= '0;
      pend_dp_q    <= '0;
      pend_en_q    <= '0;
      pend_valid_q <= 1'b0;
      act_dig_q    <= '0;
      act_dp_q     <= '0;
      act_en_q     <= '0;
      lz_q         <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      slot_cnt_q   <= slot_cnt_d;
      digit_idx_q  <= digit_idx_d;
      pend_dig_q   <= pend_dig_d;
      pend_dp_q    <= pend_dp_d;
      pend_en_q    <= pend_en_d;
      pend_valid_q <= pend_valid_d;
      act_dig_q    <= act_dig_d;
      act_dp_q     <= act_dp_d;
      act_en_q     <= act_en_d;
      lz_q         <= lz_d;
      frame_done_q <= frame_done_d;
    end
  end

  logic [NUM_DIGITS-1:0] vis;
  logic                  zero_run;
  logic                  cur_vis;
  logic                  cur_dp;
  logic                  drive;

  always_comb begin
    vis      = '0;
    zero_run = 1'b1;
    cur_vis  = 1'b0;
    cur_dp   = 1'b0;
    hex_out  = '0;
    anode    = '1;
    drive    = (state_q == DRIVE);
    // zero_run tracks "this nibble and every higher one is zero".
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_run = zero_run & (act_dig_q[4*i +: 4] == 4'h0);
      vis[i]   = act_en_q[i] & ~(lz_q & zero_run & (i != 0));
    end
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (int'(digit_idx_q) == i) begin
        hex_out  = act_dig_q[4*i +: 4];
        cur_vis  = vis[i];
        cur_dp   = act_dp_q[i];
        anode[i] = ~(drive & vis[i]);
      end
    end
    dp_out = ~(cur_dp & cur_vis & drive);
  end

  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_display_scan_controller.sv
// Bench for display_scan_controller: directed and random loads checked
// every cycle against a time-based reference model.
module tb_display_scan_controller;

  localparam int ND = 4;
  localparam int RD = 8;
  localparam int BC = 2;
  localparam int FRAME = ND * RD;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] digits_in = '0;
  logic [3:0]  dp_in = '0;
  logic [3:0]  digit_en = '0;
  logic        lz_suppress = 1'b0;
  logic        load = 1'b0;
  logic [3:0]  hex_out;
  logic [3:0]  anode;
  logic        dp_out;
  logic        frame_done;

  display_scan_controller #(
    .NUM_DIGITS  (ND),
    .REFRESH_DIV (RD),
    .BLANK_CYCLES(BC)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .digits_in  (digits_in),
    .dp_in      (dp_in),
    .digit_en   (digit_en),
    .lz_suppress(lz_suppress),
    .load       (load),
    .hex_out    (hex_out),
    .anode      (anode),
    .dp_out     (dp_out),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  int          t;
  logic [15:0] m_act_dig, m_pend_dig;
  logic [3:0]  m_act_dp, m_act_en, m_pend_dp, m_pend_en;
  bit          m_pv, m_lz, m_fd;

  task automatic model_reset();
    t = 0;
    m_act_dig = '0; m_act_dp = '0; m_act_en = '0;
    m_pend_dig = '0; m_pend_dp = '0; m_pend_en = '0;
    m_pv = 0; m_lz = 0; m_fd = 0;
  endtask

  task automatic chk(string tag, logic [15:0] got, logic [15:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s t=%0d got %h exp %h", tag, t, got, exp);
    end
  endtask

  task automatic check_all();
    int slot, dig;
    bit drive, vis;
    logic [3:0] oh, e_an, e_hex;
    bit e_dp;
    slot  = t % RD;
    dig   = (t / RD) % ND;
    drive = (slot >= BC);
    vis   = m_act_en[dig] &&
            !(m_lz && dig > 0 && (m_act_dig >> (4 * dig)) == 0);
    oh    = 4'b0001 << dig;
    e_an  = (drive && vis) ? ~oh : 4'hF;
    e_hex = m_act_dig[4*dig +: 4];
    e_dp  = !(drive && vis && m_act_dp[dig]);
    chk("anode", {12'h0, anode}, {12'h0, e_an});
    chk("hex_out", {12'h0, hex_out}, {12'h0, e_hex});
    chk("dp_out", {15'h0, dp_out}, {15'h0, e_dp});
    chk("frame_done", {15'h0, frame_done}, {15'h0, m_fd});
  endtask

  // One clock: model consumes the inputs seen at the edge, then compare.
  task automatic step();
    bit bnd;
    @(posedge clk);
    bnd = (t % FRAME) == FRAME - 1;
    if (bnd) begin
      if (load) begin
        m_act_dig = digits_in; m_act_dp = dp_in; m_act_en = digit_en;
        m_pv = 0;
      end else if (m_pv) begin
        m_act_dig = m_pend_dig; m_act_dp = m_pend_dp;
        m_act_en = m_pend_en; m_pv = 0;
      end
    end else if (load) begin
      m_pend_dig = digits_in; m_pend_dp = dp_in; m_pend_en = digit_en;
      m_pv = 1;
    end
    m_lz = lz_suppress;
    m_fd = bnd;
    t++;
    #1;
    check_all();
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic run_to(int phase);
    for (int i = 0; i < FRAME; i++) begin
      if (t % FRAME == phase) return;
      step();
    end
  endtask

  task automatic do_load(logic [15:0] d, logic [3:0] dp, logic [3:0] en);
    digits_in = d; dp_in = dp; digit_en = en; load = 1'b1;
    step();
    load = 1'b0;
  endtask

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_anode", {12'h0, anode}, 16'h000F);
    chk("rst_hex", {12'h0, hex_out}, 16'h0000);
    chk("rst_dp", {15'h0, dp_out}, 16'h0001);
    chk("rst_fd", {15'h0, frame_done}, 16'h0000);
    reset_n = 1'b1;
    check_all();

    // load at cycle 5, shown from cycle 32
    run(5);
    do_load(16'h1A3F, 4'h0, 4'hF);
    run_to(0);
    chk("fd_at_32", {15'h0, frame_done}, 16'h0001);
    run(2);
    chk("slot0_anode", {12'h0, anode}, 16'h000E);
    chk("slot0_hex", {12'h0, hex_out}, 16'h000F);
    run(FRAME);

    // leading-zero suppression
    lz_suppress = 1'b1;
    do_load(16'h0030, 4'h0, 4'hF);
    run(2 * FRAME);
    do_load(16'h0000, 4'h0, 4'hF);
    run(2 * FRAME);
    lz_suppress = 1'b0;
    run(3);

    // collision on the transfer edge
    run_to(10);
    do_load(16'h2222, 4'h0, 4'hF);
    run_to(FRAME - 1);
    do_load(16'h5555, 4'h0, 4'hF);
    run(2 * FRAME);

    // two loads in one frame
    run_to(4);
    do_load(16'h7777, 4'h0, 4'hF);
    run(6);
    do_load(16'h9876, 4'h0, 4'hF);
    run(2 * FRAME);

    // decimal point and enable
    do_load(16'h4321, 4'b0100, 4'b1011);
    run(2 * FRAME);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      logic [15:0] mask;
      if ($urandom_range(0, 7) == 0) lz_suppress = ~lz_suppress;
      if ($urandom_range(0, 9) == 0) begin
        mask = 16'hFFFF >> (4 * $urandom_range(0, 4));
        do_load(16'($urandom) & mask, 4'($urandom), 4'($urandom));
      end else begin
        step();
      end
    end
    lz_suppress = 1'b0;

    // mid-slot asynchronous reset during digit 2 drive
    do_load(16'h4321, 4'hF, 4'hF);
    run(FRAME);
    run_to(2 * RD + 4);
    chk("pre_rst_anode", {12'h0, anode}, 16'h000B);
    #2 reset_n = 1'b0;
    #1;
    chk("async_anode", {12'h0, anode}, 16'h000F);
    chk("async_hex", {12'h0, hex_out}, 16'h0000);
    chk("async_dp", {15'h0, dp_out}, 16'h0001);
    @(posedge clk);
    #1 reset_n = 1'b1;
    model_reset();
    check_all();
    run(2 * FRAME);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
